// File: rtl/wall_datapath_if.sv
// Pixel stream from the wall datapath to the VGA adapter.
// One registered pixel per cycle; plot strobes the write.
interface wall_datapath_if;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    modport master (output x, y, colour, plot);
    modport slave  (input  x, y, colour, plot);
endinterface

// File: rtl/wall_datapath.sv
// Wall position/gap datapath: erases and redraws the wall column by
// column and reports when the wall has reached the left edge.
module wall_datapath #(
    parameter int          SCREEN_H    = 120,
    parameter int          START_X     = 156,
    parameter int          WALL_W      = 4,
    parameter int          GAP_H       = 30,
    parameter int          STEP        = 1,
    parameter logic [2:0]  WALL_COLOUR = 3'b010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  current,
    input  logic        tick,
    input  logic [6:0]  gap_y,
    wall_datapath_if.master pix,
    output logic [7:0]  wall_x,
    output logic        touched,
    output logic        busy
);

    localparam int CW = (WALL_W > 1) ? $clog2(WALL_W) : 1;
    localparam int RW = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;

    localparam logic [2:0] C_READY = 3'b000;
    localparam logic [2:0] C_MOVE  = 3'b001;
    localparam logic [2:0] C_STOP  = 3'b011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   c;
    logic [RW-1:0]   r;
    logic [6:0]      gap;
    logic            restore;
    logic            col_end, last, in_gap;
    logic            start_move, start_stop;
    logic [8:0]      wx_sub;
    logic [7:0]      wx_dec;

    always_comb begin
        col_end    = (r == RW'(SCREEN_H - 1));
        last       = col_end && (c == CW'(WALL_W - 1));
        // rows past the bottom never occur, so the gap clips itself
        in_gap     = (9'(r) >= 9'(gap)) &&
                     (9'(r) <  9'(gap) + 9'(GAP_H));
        wx_sub     = {1'b0, wall_x} - 9'(STEP);
        wx_dec     = wx_sub[8] ? 8'd0 : wx_sub[7:0];
        start_stop = (current == C_STOP);
        start_move = (current == C_MOVE) && tick &&
                     (wall_x != 8'd0);
        state_n    = state;
        unique case (1'b1)
            (state == IDLE):
                if (start_stop || start_move) state_n = ERASE;
            (state == ERASE):
                if (last) state_n = restore ? IDLE : DRAW;
            (state == DRAW):
                if (last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wall_x     <= 8'(START_X);
            gap        <= '0;
            touched    <= 1'b0;
            busy       <= 1'b0;
            restore    <= 1'b0;
            c          <= '0;
            r          <= '0;
            pix.x      <= '0;
            pix.y      <= '0;
            pix.colour <= '0;
            pix.plot   <= 1'b0;
        end else begin
            // held one extra cycle so the last pixel stays inside busy
            busy <= (state != IDLE) || (state_n != IDLE);
            if (state == IDLE) begin
                pix.plot <= 1'b0;
                c        <= '0;
                r        <= '0;
                restore  <= start_stop;
                if (current == C_READY) begin
                    wall_x  <= 8'(START_X);
                    gap     <= gap_y;
                    touched <= 1'b0;
                end
            end else begin
                pix.x      <= wall_x + 8'(c);
                pix.y      <= 7'(r);
                pix.colour <= (state == DRAW) ? WALL_COLOUR : 3'b000;
                pix.plot   <= !in_gap;
                if (last) begin
                    c <= '0;
                    r <= '0;
                    if (state == ERASE)
                        wall_x <= restore ? 8'(START_X) : wx_dec;
                    else if (wall_x == 8'd0)
                        touched <= 1'b1;
                end else if (col_end) begin
                    r <= '0;
                    c <= c + 1'b1;
                end else begin
                    r <= r + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wall_datapath.sv
// Bench for wall_datapath: default instance plus a small, fast-saturating
// instance; pixel streams compared against a list-based model.
module tb_wall_datapath;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] current;
    logic       tick;
    logic [6:0] gap_y;

    always #5 clk = ~clk;

    wall_datapath_if pd();
    wall_datapath_if ps();

    logic [7:0] wx_d, wx_s;
    logic       t_d, t_s, b_d, b_s;

    wall_datapath u_dut (
        .clk(clk), .reset(reset), .current(current), .tick(tick),
        .gap_y(gap_y), .pix(pd), .wall_x(wx_d), .touched(t_d),
        .busy(b_d)
    );

    wall_datapath #(
        .SCREEN_H(10), .START_X(5), .WALL_W(2), .GAP_H(3), .STEP(2)
    ) u_small (
        .clk(clk), .reset(reset), .current(current), .tick(tick),
        .gap_y(gap_y), .pix(ps), .wall_x(wx_s), .touched(t_s),
        .busy(b_s)
    );

    localparam logic [2:0] READY = 3'b000;
    localparam logic [2:0] MOVE  = 3'b001;
    localparam logic [2:0] STOP  = 3'b011;
    localparam logic [2:0] WC    = 3'b010;

    bit         sel;
    logic [7:0] o_x, o_wx;
    logic [6:0] o_y;
    logic [2:0] o_col;
    logic       o_plot, o_busy, o_touch;

    assign o_x     = sel ? ps.x      : pd.x;
    assign o_y     = sel ? ps.y      : pd.y;
    assign o_col   = sel ? ps.colour : pd.colour;
    assign o_plot  = sel ? ps.plot   : pd.plot;
    assign o_wx    = sel ? wx_s      : wx_d;
    assign o_busy  = sel ? b_s       : b_d;
    assign o_touch = sel ? t_s       : t_d;

    int checks   = 0;
    int failures = 0;

    int H, W, GH, SX, ST;
    int mwx, mgap;
    bit mtouch;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setsel(input bit s);
        sel = s;
        if (s) begin
            H = 10;  W = 2; GH = 3;  SX = 5;   ST = 2;
        end else begin
            H = 120; W = 4; GH = 30; SX = 156; ST = 1;
        end
    endtask

    task automatic ready(input int g, input int n);
        current = READY;
        tick    = 1'b0;
        gap_y   = 7'(g);
        repeat (n) begin
            step();
            chk("ready_wall_x", o_wx, SX);
            chk("ready_touched", o_touch, 0);
            chk("ready_busy", o_busy, 0);
            chk("ready_plot", o_plot, 0);
        end
        mwx    = SX;
        mgap   = g;
        mtouch = 1'b0;
        current = MOVE;
    endtask

    task automatic sweep(input bit stop, input bit noise);
        logic [17:0] expq[$];
        logic [17:0] gotq[$];
        int n, bad, nx, lat, mi, last_i;
        expq = {};
        gotq = {};
        for (int c = 0; c < W; c++)
            for (int r = 0; r < H; r++)
                if (!(r >= mgap && r < mgap + GH))
                    expq.push_back({8'(mwx + c), 7'(r), 3'b000});
        if (stop) nx = SX;
        else nx = (mwx - ST < 0) ? 0 : mwx - ST;
        if (!stop)
            for (int c = 0; c < W; c++)
                for (int r = 0; r < H; r++)
                    if (!(r >= mgap && r < mgap + GH))
                        expq.push_back({8'(nx + c), 7'(r), WC});
        lat = stop ? W * H + 1 : 2 * W * H + 1;

        current = stop ? STOP : MOVE;
        tick    = 1'b1;
        step();
        current = MOVE;
        tick    = 1'b0;
        chk("accept_busy", o_busy, 1);
        n   = 0;
        bad = 0;
        while (o_busy === 1'b1 && n < 3000) begin
            if (noise && n < lat - 20) begin
                tick    = ($urandom_range(0, 7) == 0);
                current = 3'($urandom_range(0, 7));
                gap_y   = 7'($urandom);
            end else begin
                tick    = 1'b0;
                current = MOVE;
            end
            step();
            n++;
            if (o_plot === 1'b1) begin
                gotq.push_back({o_x, o_y, o_col});
                if (o_busy !== 1'b1) bad++;
            end
        end
        tick    = 1'b0;
        current = MOVE;
        chk("latency", n, lat);
        chk("plot_while_idle", bad, 0);
        chk("pixel_count", gotq.size(), expq.size());
        mi = -1;
        for (int i = 0; i < gotq.size() && i < expq.size(); i++)
            if (mi < 0 && gotq[i] !== expq[i]) mi = i;
        last_i = (gotq.size() < expq.size()) ? gotq.size() - 1
                                             : expq.size() - 1;
        if (mi < 0) mi = last_i;
        if (mi >= 0) chk("pixel_xyc", gotq[mi], expq[mi]);
        mwx = nx;
        if (!stop && nx == 0) mtouch = 1'b1;
        chk("sweep_wall_x", o_wx, mwx);
        chk("sweep_touched", o_touch, mtouch);
    endtask

    initial begin
        setsel(1'b0);
        reset   = 1'b1;
        current = READY;
        tick    = 1'b0;
        gap_y   = '0;
        repeat (2) step();
        chk("rst_wall_x", o_wx, 156);
        chk("rst_touched", o_touch, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_plot", o_plot, 0);
        chk("rst_x", o_x, 0);
        chk("rst_y", o_y, 0);
        chk("rst_colour", o_col, 0);
        reset = 1'b0;

        ready(40, 3);
        sweep(1'b0, 1'b1);
        sweep(1'b0, 1'b0);

        ready(100, 2);
        sweep(1'b0, 1'b1);

        repeat (2) begin
            ready($urandom_range(0, 127), 1);
            sweep(1'b0, 1'b1);
        end

        ready(40, 1);
        sweep(1'b0, 1'b0);
        sweep(1'b1, 1'b0);

        current = MOVE;
        tick    = 1'b1;
        step();
        tick    = 1'b0;
        repeat (200) step();
        chk("mid_erase_busy", o_busy, 1);
        reset = 1'b1;
        step();
        chk("abort_plot", o_plot, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_wall_x", o_wx, 156);
        chk("abort_touched", o_touch, 0);
        reset = 1'b0;

        setsel(1'b1);
        ready(7, 2);
        sweep(1'b0, 1'b1);
        sweep(1'b0, 1'b1);
        sweep(1'b0, 1'b0);

        current = MOVE;
        tick    = 1'b1;
        step();
        tick    = 1'b0;
        repeat (4) begin
            chk("sat_busy", o_busy, 0);
            chk("sat_plot", o_plot, 0);
            chk("sat_wall_x", o_wx, 0);
            chk("sat_touched", o_touch, 1);
            step();
        end

        ready(8, 1);
        sweep(1'b0, 1'b1);
        sweep(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wall_datapath.md
Name: wall_datapath

Overview:
- Datapath stage directly downstream of the wall control FSM.
- Consumes the 3-bit wall state code and holds the wall's horizontal position and gap position.
- Rasterises the wall (erase old column, draw new column) as a pixel stream for the VGA adapter.
- Produces the `touched` feedback signal that the wall FSM consumes.

Parameters:
- SCREEN_H, default 120: visible rows; the sweep covers rows 0..SCREEN_H-1.
- START_X, default 156: wall_x load value (SCREEN_W 160 minus WALL_W).
- WALL_W, default 4: wall width in pixels.
- GAP_H, default 30: height of the opening, in rows.
- STEP, default 1: pixels moved left per accepted move.
- WALL_COLOUR, default 3'b010: draw colour. Erase colour is fixed at 3'b000.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- current, input, 3: wall state code. 000 = READY, 001 = MOVE, 011 = STOP, 111 = DRAW.
- tick, input, 1: one-cycle move-enable pulse (frame rate).
- gap_y, input, 7: top row of the opening; sampled in READY.
- x, output, 8: pixel x coordinate (registered).
- y, output, 7: pixel y coordinate (registered).
- colour, output, 3: pixel colour (registered).
- plot, output, 1: pixel write strobe (registered).
- wall_x, output, 8: current left column of the wall.
- touched, output, 1: wall has reached the left edge (level).
- busy, output, 1: raster sweep in progress.

Behaviour:
- Reset (synchronous, active-high; dominates all other inputs):
  - wall_x = START_X; latched gap = 0; touched = 0; busy = 0; plot = 0; x = 0; y = 0; colour = 0; internal FSM = IDLE.
  - A reset asserted mid-sweep aborts the sweep; plot is 0 on the following cycle.
- Internal FSM states: IDLE, ERASE, DRAW.
- IDLE behaviour by state code:
  - READY: every cycle, wall_x <= START_X, gap latch <= gap_y, touched <= 0. No pixels are emitted.
  - MOVE with tick=1 and wall_x != 0: go to ERASE (busy=1).
  - MOVE with tick=1 and wall_x == 0: ignored; no sweep, no position change.
  - STOP: go to ERASE. Set a restore flag so that, at the end of ERASE, wall_x <= START_X and the FSM returns to IDLE with no DRAW phase.
  - DRAW, or any undefined code: no action.
- ERASE / DRAW sweep:
  - Column counter c runs 0..WALL_W-1 (outer); row counter r runs 0..SCREEN_H-1 (inner). Each phase takes WALL_W*SCREEN_H cycles (480 at defaults), one pixel per cycle.
  - Pixel for (c, r): x = wall_x + c, y = r.
  - plot = 1 unless gap <= r < gap + GAP_H. Inside the gap, plot = 0 but the counters still advance.
  - The gap is clipped at SCREEN_H: if gap + GAP_H > SCREEN_H, rows from gap to the bottom are skipped.
  - colour = 3'b000 in ERASE, WALL_COLOUR in DRAW.
  - Outputs are registered: a pixel appears 1 cycle after its counter value.
- Position update at the end of ERASE (move case):
  - wall_x <= wall_x - STEP, saturating at 0. Compute at 9 bits; clamp negative results to 0.
  - Counters reset; go to DRAW. DRAW uses the updated wall_x.
- End of DRAW:
  - Go to IDLE; busy = 0 on the next cycle.
  - touched <= 1 if wall_x == 0.
- touched stays high until the next cycle in READY.
- Total move latency: tick accepted to busy falling = 2*WALL_W*SCREEN_H + 1 cycles.
- Events while busy:
  - tick pulses are dropped, not queued.
  - Changes on current are ignored until IDLE; a sweep always completes.
  - gap_y changes are ignored; the gap is latched only in READY.
- Simultaneous tick and STOP code in IDLE: STOP wins.
- plot is never 1 while busy = 0.

Test Plan:
- Reset, then hold READY with gap_y=40 for 3 cycles -> wall_x=156, touched=0, busy=0, plot=0 every cycle.
- MOVE plus one tick, gap_y=40 -> 960-cycle sweep.
  - ERASE: 360 plotted pixels at colour 0, x=156..159.
  - DRAW: 360 plotted pixels at colour 3'b010, x=155..158.
  - No plot for y=40..69; final wall_x=155.
- Extra tick pulses during a sweep -> ignored; exactly one decrement (wall_x goes 156->155, not 154).
- Preload wall_x=1 via repeated moves, then one more tick -> wall_x=0, touched=1 after DRAW. A further tick -> no sweep, wall_x stays 0. Returning to READY -> touched=0, wall_x=156.
- gap_y=100 -> rows 100..119 skipped (clipped gap); rows 0..99 plotted.
- Assert reset at cycle 200 of ERASE -> plot=0 and busy=0 the next cycle, wall_x=156.
- STOP code in IDLE -> erase-only sweep of 480 cycles, then wall_x=156 with no DRAW pixels.
